// File: rtl/nanosoc_region_bootrom_ws.sv
// AHB-Lite bootrom region with wait states, external async ROM port and ERROR response.
// Optional one-entry line buffer enabled by NANOSOC_BOOTROM_LINEBUF_EN.
module nanosoc_region_bootrom_ws #(
    parameter int SYS_ADDR_W     = 32,
    parameter int SYS_DATA_W     = 32,
    parameter int BOOTROM_ADDR_W = 10,
    parameter int WAIT_STATES    = 1,
    localparam int ADDR_LSB      = (SYS_DATA_W == 64) ? 3 : 2,
    localparam int ROM_AW        = BOOTROM_ADDR_W - ADDR_LSB
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [SYS_ADDR_W-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [SYS_DATA_W-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [SYS_DATA_W-1:0] HRDATA,
    output logic                  ROM_EN,
    output logic [ROM_AW-1:0]     ROM_ADDR,
    input  logic [SYS_DATA_W-1:0] ROM_RDATA
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ROM_AW-1:0]     addr_q, addr_d;
    logic                  take;
    logic                  rd_ok;
    logic                  load_rd;
    logic                  last_rd;
    logic [ROM_AW-1:0]     new_wa;
    logic                  hit_c;
    logic                  hit_r;
    logic [SYS_DATA_W-1:0] hit_data;

    logic unused_ok;
    assign unused_ok = ^{HPROT, HWDATA, HTRANS[0],
                         HADDR[SYS_ADDR_W-1:BOOTROM_ADDR_W],
                         HADDR[ADDR_LSB-1:0]};

    assign take    = HSEL & HREADY & HTRANS[1];
    assign rd_ok   = ~HWRITE & (HSIZE <= 3'(ADDR_LSB));
    assign new_wa  = HADDR[BOOTROM_ADDR_W-1:ADDR_LSB];
    assign last_rd = (state_q == S_READ) && (cnt_q == 4'd0);

`ifdef NANOSOC_BOOTROM_LINEBUF_EN
    logic                  buf_v_q, buf_v_d;
    logic [ROM_AW-1:0]     buf_a_q, buf_a_d;
    logic [SYS_DATA_W-1:0] buf_w_q, buf_w_d;
    logic                  fill;
    logic                  hit_q;

    // Fill is forwarded so a pipelined re-read of the completing word hits.
    always_comb begin
        fill    = last_rd & ~hit_q;
        buf_v_d = buf_v_q | fill;
        buf_a_d = fill ? addr_q : buf_a_q;
        buf_w_d = fill ? ROM_RDATA : buf_w_q;
        hit_c   = buf_v_d && (buf_a_d == new_wa);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            buf_v_q <= 1'b0;
            buf_a_q <= '0;
            buf_w_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            buf_v_q <= buf_v_d;
            buf_a_q <= buf_a_d;
            buf_w_q <= buf_w_d;
            hit_q   <= load_rd & hit_c;
        end
    end

    assign hit_r    = hit_q;
    assign hit_data = buf_w_q;
`else
    assign hit_c    = 1'b0;
    assign hit_r    = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        load_rd = 1'b0;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if ((state_q == S_READ) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else if (take && rd_ok) begin
            state_d = S_READ;
            load_rd = 1'b1;
            cnt_d   = hit_c ? 4'd0 : 4'(WAIT_STATES);
            addr_d  = hit_c ? addr_q : new_wa;
        end else if (take) begin
            state_d = S_ERR1;
            cnt_d   = 4'd0;
        end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        ROM_EN    = 1'b0;
        HRDATA    = '0;
        unique case (state_q)
            S_IDLE: begin
                HREADYOUT = 1'b1;
            end
            S_READ: begin
                ROM_EN    = ~hit_r;
                HREADYOUT = (cnt_q == 4'd0);
                if (last_rd) HRDATA = hit_r ? hit_data : ROM_RDATA;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
        endcase
    end

    assign ROM_ADDR = addr_q;

endmodule

// File: doc/nanosoc_region_bootrom_ws.md
Name: nanosoc_region_bootrom_ws

Overview:
Parametrised AHB-Lite bootrom region: successor to the fixed single-cycle bootrom region. Adds:
- configurable wait states for slow ROM macros
- an external asynchronous-read ROM port
- a two-cycle ERROR response for writes and oversize transfers

Sits on the nanosoc bus matrix at 0x10000000-0x1fffffff, remapped to 0x00000000 at boot.

Parameters:
SYS_ADDR_W, 32, system address width
SYS_DATA_W, 32, data width; 32 or 64 only; ADDR_LSB = 2 (32) or 3 (64)
BOOTROM_ADDR_W, 10, byte-address width of ROM (default 1KB); upper HADDR bits ignored (aliasing)
WAIT_STATES, 1, extra data-phase cycles per read, 0..15

Ports:
HCLK  input  1  clock
HRESET  input  1  synchronous active-high reset
HSEL  input  1  region select
HADDR  input  SYS_ADDR_W  address
HTRANS  input  2  transfer type
HSIZE  input  3  transfer size
HPROT  input  4  protection (ignored)
HWRITE  input  1  write flag
HREADY  input  1  bus ready
HWDATA  input  SYS_DATA_W  write data (ignored)
HREADYOUT  output  1  slave ready
HRESP  output  1  1 = ERROR
HRDATA  output  SYS_DATA_W  read data
ROM_EN  output  1  ROM enable, high throughout a read data phase
ROM_ADDR  output  BOOTROM_ADDR_W-ADDR_LSB  registered word address
ROM_RDATA  input  SYS_DATA_W  asynchronous ROM read data

Behaviour:
- Clock/reset: one clock, HCLK. Reset HRESET is synchronous and active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, ROM_EN=0, ROM_ADDR=0, state=IDLE, wait counter=0.
- Accept: on a rising edge with HSEL & HREADY & HTRANS[1]. IDLE/BUSY transfers (HTRANS[1]=0) give a zero-wait OKAY response and change no state.
- Classification of accepted transfers:
  - read with HSIZE <= log2(SYS_DATA_W/8) -> READ
  - write, or oversize read -> ERR1
- ROM_ADDR is loaded with HADDR[BOOTROM_ADDR_W-1:ADDR_LSB] only on an accepted READ. It holds until the next accepted READ.
- States:
  - IDLE: HREADYOUT=1, HRESP=0, ROM_EN=0.
  - READ: ROM_EN=1, HRESP=0. Counter loads WAIT_STATES on accept and decrements each cycle. HREADYOUT=0 while counter != 0.
    - At counter == 0: HREADYOUT=1 and HRDATA=ROM_RDATA (combinational).
    - If a new transfer is accepted in that cycle (pipelined), go to READ/ERR1 per the new transfer; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, ROM_EN=0, then go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, then IDLE, or READ/ERR1 if a new transfer is accepted.
- Read latency: WAIT_STATES+1 data-phase cycles. With WAIT_STATES=0, back-to-back reads sustain one per cycle.
- HRDATA is 0 in every cycle other than the final READ cycle. The full word is always returned; the master selects byte lanes.
- Transfers arriving while HREADYOUT=0 are not accepted, because HREADY is low.
- Reset asserted mid-transfer: next edge forces reset values. Any pending response is dropped.

Optional Feature:
Macro NANOSOC_BOOTROM_LINEBUF_EN.
- With the macro: a one-entry line buffer holds {valid, word address, data}.
  - Filled at the completion of every READ.
  - An accepted READ whose word address equals the buffered address while valid=1 completes with zero wait states.
  - Such a hit returns the buffered data, with ROM_EN=0 and ROM_ADDR unchanged.
  - valid is cleared by HRESET.
- Without the macro: no buffer; every READ takes WAIT_STATES+1 cycles.

Test Plan:
- Reset, then idle bus -> HREADYOUT=1, HRESP=0, HRDATA=0, ROM_EN=0.
- WAIT_STATES=2; read HADDR=0x10000010 with ROM word 4 = 0xDEADBEEF -> ROM_ADDR=4, two cycles HREADYOUT=0, third cycle HREADYOUT=1 and HRDATA=0xDEADBEEF.
- WAIT_STATES=0; back-to-back reads of 0x0, 0x4, 0x8 (NONSEQ/SEQ) -> three consecutive OKAY cycles returning ROM words 0, 1, 2.
- Word write to 0x10000020 -> cycle 1: HREADYOUT=0, HRESP=1; cycle 2: HREADYOUT=1, HRESP=1; ROM_EN stays 0; ROM_ADDR unchanged.
- Aliasing with BOOTROM_ADDR_W=10: read 0x10000404 -> ROM_ADDR=1. With NANOSOC_BOOTROM_LINEBUF_EN and WAIT_STATES=3, two reads of 0x8 -> the second completes in 1 cycle with ROM_EN=0.
- Reset asserted during a READ wait cycle -> next cycle HREADYOUT=1, ROM_EN=0, state IDLE. A following read completes normally.
